// File: rtl/mult_unit_if.sv
// Request/result bundle between the execute-stage controller and mult_unit.
// The master drives the operation and HI/LO write strobes; the unit returns results and stall status.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 sign;
  logic [1:0]           mode;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 is_busbusy;
  logic                 hilo_we;
  logic                 hilo_sel;
  logic [WIDTH-1:0]     hilo_wdata;
  logic [2*WIDTH-1:0]   P;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;
  logic                 busy;
  logic                 opreat_over;

  modport master (
    output start, sign, mode, A, B, is_busbusy, hilo_we, hilo_sel, hilo_wdata,
    input  P, hi, lo, busy, opreat_over
  );

  modport slave (
    input  start, sign, mode, A, B, is_busbusy, hilo_we, hilo_sel, hilo_wdata,
    output P, hi, lo, busy, opreat_over
  );
endinterface

// File: rtl/mult_unit.sv
// Multi-cycle multiply / multiply-accumulate unit with internal HI/LO registers.
// Stalls the pipeline via opreat_over while running and waits out downstream backpressure before committing.
module mult_unit #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3,
  parameter bit ACC_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  mult_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT_C = 4'(LATENCY);

  state_t                    state_q, state_d;
  logic [3:0]                count_q, count_d;
  logic [WIDTH-1:0]          a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]          hi_q, hi_d, lo_q, lo_d;
  logic                      sign_q, sign_d;
  logic [1:0]                mode_q, mode_d;
  logic signed [2*WIDTH-1:0] a_ext, b_ext, prod, acc, p_res;

  function automatic logic signed [2*WIDTH-1:0] extend(input logic [WIDTH-1:0] v,
                                                       input logic sgn);
    extend = sgn ? {{WIDTH{v[WIDTH-1]}}, v} : {{WIDTH{1'b0}}, v};
  endfunction

  // Result path reads only latched operands and HI/LO, so A/B never reach P combinationally.
  // A 2*WIDTH product of extended operands, truncated, is exact modulo 2^(2*WIDTH) for both signednesses.
  always_comb begin
    a_ext = extend(a_q, sign_q);
    b_ext = extend(b_q, sign_q);
    prod  = a_ext * b_ext;
    acc   = {hi_q, lo_q};
    p_res = prod;
    if (ACC_EN) begin
      case (mode_q)
        2'b01:   p_res = acc + prod;
        2'b10:   p_res = acc - prod;
        default: p_res = prod;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    mode_d  = mode_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.hilo_we) begin
          if (bus.hilo_sel) hi_d = bus.hilo_wdata;
          else              lo_d = bus.hilo_wdata;
        end
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          sign_d  = bus.sign;
          mode_d  = bus.mode;
          count_d = 4'd1;
          state_d = (LAT_C == 4'd1) ? DONE : RUN;
        end
      end
      RUN: begin
        // count reaches LATENCY on the edge that enters DONE
        count_d = count_q + 4'd1;
        if (count_d == LAT_C) state_d = DONE;
      end
      DONE: begin
        if (!bus.is_busbusy) begin
          {hi_d, lo_d} = p_res;
          count_d      = 4'd0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      mode_q  <= 2'b00;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      mode_q  <= mode_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.P           = p_res;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = (state_q == RUN) || (state_q == DONE);
  assign bus.opreat_over = (state_q == DONE) || ((state_q == IDLE) && !bus.start);
endmodule
